// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes and cache-miss freezes
// for the 5-stage core, plus saturating stall/flush performance counters.
module hazard_control_unit #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int COUNTER_WIDTH    = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [4:0]               RS1_ADDRESS_DEC,
    input  logic [4:0]               RS2_ADDRESS_DEC,
    input  logic                     RS1_USED_DEC,
    input  logic                     RS2_USED_DEC,
    input  logic [4:0]               RD_ADDRESS_EX,
    input  logic [2:0]               DATA_CACHE_LOAD_EX,
    input  logic                     RD_WRITE_ENABLE_EX,
    input  logic                     BRANCH_TAKEN_EX,
    input  logic                     ICACHE_READY,
    input  logic                     DCACHE_READY,
    input  logic                     CLEAR_COUNTERS,
    output logic                     STALL_PROGRAM_COUNTER,
    output logic                     STALL_FETCH_STAGE,
    output logic                     CLEAR_FETCH_STAGE,
    output logic                     STALL_DECODING_STAGE,
    output logic                     CLEAR_DECODING_STAGE,
    output logic                     STALL_EXECUTION_STAGE,
    output logic                     STALL_MEMORY_STAGE,
    output logic [COUNTER_WIDTH-1:0] STALL_CYCLE_COUNT,
    output logic [COUNTER_WIDTH-1:0] FLUSH_COUNT
);

    localparam logic [1:0] ST_RESET_FLUSH = 2'd0;
    localparam logic [1:0] ST_RUN         = 2'd1;
    localparam logic [1:0] ST_LOAD_USE    = 2'd2;
    localparam logic [1:0] ST_DMISS       = 2'd3;

    localparam logic [1:0]               BUBBLES_M1 = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX    = '1;

    logic [1:0]               state_q, state_d, eval_state;
    logic [1:0]               bubble_cnt_q, bubble_cnt_d;
    logic                     ret_lu_q, ret_lu_d;
    logic [COUNTER_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [COUNTER_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic flush_event;
    logic stall_any;
    logic stall_pc, stall_f, clear_f, stall_d, clear_d, stall_e, stall_m;

    assign load_use = (DATA_CACHE_LOAD_EX != 3'd0) && RD_WRITE_ENABLE_EX &&
                      (RD_ADDRESS_EX != 5'd0) &&
                      ((RS1_USED_DEC && (RS1_ADDRESS_DEC == RD_ADDRESS_EX)) ||
                       (RS2_USED_DEC && (RS2_ADDRESS_DEC == RD_ADDRESS_EX)));

    always_comb begin
        stall_pc     = 1'b0;
        stall_f      = 1'b0;
        clear_f      = 1'b0;
        stall_d      = 1'b0;
        clear_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_event  = 1'b0;
        state_d      = state_q;
        bubble_cnt_d = bubble_cnt_q;
        ret_lu_d     = ret_lu_q;

        // A miss that ends this cycle hands control straight back to the
        // interrupted state, so the return state's decision is made now.
        eval_state = state_q;
        if (state_q == ST_DMISS && DCACHE_READY)
            eval_state = ret_lu_q ? ST_LOAD_USE : ST_RUN;

        case (eval_state)
            ST_RESET_FLUSH: begin
                clear_f = 1'b1;
                clear_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
                if (!DCACHE_READY) begin
                    {stall_pc, stall_f, stall_d, stall_e, stall_m} = 5'b11111;
                    ret_lu_d = 1'b0;
                    state_d  = ST_DMISS;
                end else if (BRANCH_TAKEN_EX) begin
                    clear_f     = 1'b1;
                    clear_d     = 1'b1;
                    flush_event = 1'b1;
                end else if (load_use) begin
                    stall_pc = 1'b1;
                    stall_f  = 1'b1;
                    clear_d  = 1'b1;
                    if (LOAD_USE_BUBBLES > 1) begin
                        bubble_cnt_d = BUBBLES_M1;
                        state_d      = ST_LOAD_USE;
                    end
                end else if (!ICACHE_READY) begin
                    stall_pc = 1'b1;
                    clear_f  = 1'b1;
                end
            end
            ST_LOAD_USE: begin
                if (!DCACHE_READY) begin
                    {stall_pc, stall_f, stall_d, stall_e, stall_m} = 5'b11111;
                    ret_lu_d = 1'b1;
                    state_d  = ST_DMISS;
                end else begin
                    stall_pc     = 1'b1;
                    stall_f      = 1'b1;
                    clear_d      = 1'b1;
                    bubble_cnt_d = bubble_cnt_q - 2'd1;
                    state_d      = (bubble_cnt_q == 2'd1) ? ST_RUN : ST_LOAD_USE;
                end
            end
            default: begin
                {stall_pc, stall_f, stall_d, stall_e, stall_m} = 5'b11111;
                state_d = ST_DMISS;
            end
        endcase
    end

    assign stall_any = stall_pc | stall_f | stall_d | stall_e | stall_m;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CLEAR_COUNTERS) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_any && stall_cnt_q != CNT_MAX)
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush_event && flush_cnt_q != CNT_MAX)
                flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_RESET_FLUSH;
            bubble_cnt_q <= 2'd0;
            ret_lu_q     <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            bubble_cnt_q <= bubble_cnt_d;
            ret_lu_q     <= ret_lu_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign STALL_PROGRAM_COUNTER = stall_pc;
    assign STALL_FETCH_STAGE     = stall_f;
    assign CLEAR_FETCH_STAGE     = clear_f;
    assign STALL_DECODING_STAGE  = stall_d;
    assign CLEAR_DECODING_STAGE  = clear_d;
    assign STALL_EXECUTION_STAGE = stall_e;
    assign STALL_MEMORY_STAGE    = stall_m;
    assign STALL_CYCLE_COUNT     = stall_cnt_q;
    assign FLUSH_COUNT           = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: three instances (1 bubble, 2 bubbles,
// 4-bit counters) share one stimulus stream; control outputs checked mid-cycle.
module tb_hazard_control_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, we, branch, iready, dready, clr;
    logic [2:0] ld;

    // {STALL_PC, STALL_F, CLEAR_F, STALL_D, CLEAR_D, STALL_E, STALL_M}
    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] FLUSH  = 7'b0010100;
    localparam logic [6:0] BUBBLE = 7'b1100100;
    localparam logic [6:0] IMISS  = 7'b1010000;
    localparam logic [6:0] FREEZE = 7'b1101011;

    logic [6:0]  ctl1, ctl2, ctl3;
    logic [15:0] sc1, fc1, sc2, fc2;
    logic [3:0]  sc3, fc3;

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit #(.LOAD_USE_BUBBLES(1), .COUNTER_WIDTH(16)) u1 (
        .CLK(clk), .RST_N(rst_n),
        .RS1_ADDRESS_DEC(rs1), .RS2_ADDRESS_DEC(rs2),
        .RS1_USED_DEC(rs1_used), .RS2_USED_DEC(rs2_used),
        .RD_ADDRESS_EX(rd), .DATA_CACHE_LOAD_EX(ld), .RD_WRITE_ENABLE_EX(we),
        .BRANCH_TAKEN_EX(branch), .ICACHE_READY(iready), .DCACHE_READY(dready),
        .CLEAR_COUNTERS(clr),
        .STALL_PROGRAM_COUNTER(ctl1[6]), .STALL_FETCH_STAGE(ctl1[5]),
        .CLEAR_FETCH_STAGE(ctl1[4]), .STALL_DECODING_STAGE(ctl1[3]),
        .CLEAR_DECODING_STAGE(ctl1[2]), .STALL_EXECUTION_STAGE(ctl1[1]),
        .STALL_MEMORY_STAGE(ctl1[0]),
        .STALL_CYCLE_COUNT(sc1), .FLUSH_COUNT(fc1)
    );

    hazard_control_unit #(.LOAD_USE_BUBBLES(2), .COUNTER_WIDTH(16)) u2 (
        .CLK(clk), .RST_N(rst_n),
        .RS1_ADDRESS_DEC(rs1), .RS2_ADDRESS_DEC(rs2),
        .RS1_USED_DEC(rs1_used), .RS2_USED_DEC(rs2_used),
        .RD_ADDRESS_EX(rd), .DATA_CACHE_LOAD_EX(ld), .RD_WRITE_ENABLE_EX(we),
        .BRANCH_TAKEN_EX(branch), .ICACHE_READY(iready), .DCACHE_READY(dready),
        .CLEAR_COUNTERS(clr),
        .STALL_PROGRAM_COUNTER(ctl2[6]), .STALL_FETCH_STAGE(ctl2[5]),
        .CLEAR_FETCH_STAGE(ctl2[4]), .STALL_DECODING_STAGE(ctl2[3]),
        .CLEAR_DECODING_STAGE(ctl2[2]), .STALL_EXECUTION_STAGE(ctl2[1]),
        .STALL_MEMORY_STAGE(ctl2[0]),
        .STALL_CYCLE_COUNT(sc2), .FLUSH_COUNT(fc2)
    );

    hazard_control_unit #(.LOAD_USE_BUBBLES(1), .COUNTER_WIDTH(4)) u3 (
        .CLK(clk), .RST_N(rst_n),
        .RS1_ADDRESS_DEC(rs1), .RS2_ADDRESS_DEC(rs2),
        .RS1_USED_DEC(rs1_used), .RS2_USED_DEC(rs2_used),
        .RD_ADDRESS_EX(rd), .DATA_CACHE_LOAD_EX(ld), .RD_WRITE_ENABLE_EX(we),
        .BRANCH_TAKEN_EX(branch), .ICACHE_READY(iready), .DCACHE_READY(dready),
        .CLEAR_COUNTERS(clr),
        .STALL_PROGRAM_COUNTER(ctl3[6]), .STALL_FETCH_STAGE(ctl3[5]),
        .CLEAR_FETCH_STAGE(ctl3[4]), .STALL_DECODING_STAGE(ctl3[3]),
        .CLEAR_DECODING_STAGE(ctl3[2]), .STALL_EXECUTION_STAGE(ctl3[1]),
        .STALL_MEMORY_STAGE(ctl3[0]),
        .STALL_CYCLE_COUNT(sc3), .FLUSH_COUNT(fc3)
    );

    // A taken branch can never resolve while the two-bubble instance is mid load-use.
    always @(posedge clk) begin
        if (rst_n && u2.state_q == 2'd2 && branch) begin
            miscompares++;
            $display("FAIL branch_in_load_use: branch=%b while state=LOAD_USE required no branch", branch);
        end
    end

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        rd = 5'd0; ld = 3'd0; we = 1'b0; branch = 1'b0;
        iready = 1'b1; dready = 1'b1; clr = 1'b0;
    endtask

    task automatic lw_hit_rs2(input logic [4:0] r);
        idle();
        ld = 3'b010; we = 1'b1; rd = r; rs2 = r; rs2_used = 1'b1;
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        chk("reset_ctl", ctl1, FLUSH);
        chk_cnt("reset_stall_cnt", sc1, 16'd0);
        chk_cnt("reset_flush_cnt", fc1, 16'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("reset_release_first", ctl1, FLUSH);
        @(negedge clk); #1;
        chk("reset_release_run", ctl1, NONE);
        $display("reset: release sequence checked");
    endtask

    task automatic test_load_use();
        @(negedge clk); lw_hit_rs2(5'd5); #1;
        chk("lu_rs2_u1", ctl1, BUBBLE);
        chk("lu_rs2_u2", ctl2, BUBBLE);
        @(negedge clk); idle(); #1;
        chk("lu_after_u1", ctl1, NONE);
        chk("lu_second_u2", ctl2, BUBBLE);
        chk_cnt("lu_stall_cnt_u1", sc1, 16'd1);
        @(negedge clk); #1;
        chk("lu_done_u2", ctl2, NONE);
        @(negedge clk); lw_hit_rs2(5'd0); #1;
        chk("lu_rd_x0", ctl1, NONE);
        @(negedge clk); lw_hit_rs2(5'd5); rs2_used = 1'b0; #1;
        chk("lu_rs2_unused", ctl1, NONE);
        @(negedge clk); lw_hit_rs2(5'd7); we = 1'b0; #1;
        chk("lu_no_write", ctl1, NONE);
        @(negedge clk); idle(); ld = 3'b100; we = 1'b1; rd = 5'd9;
        rs1 = 5'd9; rs1_used = 1'b1; rs2 = 5'd3; rs2_used = 1'b1; #1;
        chk("lu_rs1_hit", ctl1, BUBBLE);
        @(negedge clk); idle(); #1;
        @(negedge clk); #1;
        chk("lu_rs1_settled_u2", ctl2, NONE);
        $display("load_use: bubble lengths and qualifiers checked");
    endtask

    task automatic test_branch_priority();
        @(negedge clk); lw_hit_rs2(5'd5); branch = 1'b1; iready = 1'b0; #1;
        chk("br_prio_u1", ctl1, FLUSH);
        chk("br_prio_u2", ctl2, FLUSH);
        chk_cnt("br_flush_before", fc1, 16'd0);
        @(negedge clk); idle(); #1;
        chk("br_after_u2", ctl2, NONE);
        chk_cnt("br_flush_after", fc1, 16'd1);
        $display("branch_priority: flush overrides load-use and icache miss");
    endtask

    task automatic test_back_to_back();
        @(negedge clk); idle(); branch = 1'b1; #1;
        chk("b2b_br1", ctl1, FLUSH);
        @(negedge clk); #1;
        chk("b2b_br2", ctl1, FLUSH);
        @(negedge clk); lw_hit_rs2(5'd11); #1;
        chk_cnt("b2b_flush_cnt", fc1, 16'd3);
        chk("b2b_lu1", ctl1, BUBBLE);
        @(negedge clk); #1;
        chk("b2b_lu2", ctl1, BUBBLE);
        @(negedge clk); idle(); #1;
        @(negedge clk); #1;
        chk("b2b_settled_u2", ctl2, NONE);
        $display("back_to_back: consecutive flushes and bubbles checked");
    endtask

    task automatic test_imiss();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); iready = 1'b0; #1;
            chk("imiss_cycle", ctl1, IMISS);
        end
        @(negedge clk); idle(); #1;
        chk("imiss_end", ctl1, NONE);
        $display("imiss: three fetch-miss cycles checked");
    endtask

    task automatic test_dmiss_load_use();
        @(negedge clk); idle(); clr = 1'b1; #1;
        @(negedge clk); lw_hit_rs2(5'd5); #1;
        chk_cnt("dm_cleared", sc2, 16'd0);
        chk("dm_bubble1", ctl2, BUBBLE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); dready = 1'b0; #1;
            chk("dm_freeze_u2", ctl2, FREEZE);
        end
        @(negedge clk); idle(); #1;
        chk("dm_resume_bubble_u2", ctl2, BUBBLE);
        chk("dm_resume_run_u1", ctl1, NONE);
        @(negedge clk); #1;
        chk("dm_done_u2", ctl2, NONE);
        chk_cnt("dm_stall_cnt_u2", sc2, 16'd6);
        chk_cnt("dm_stall_cnt_u1", sc1, 16'd5);
        $display("dmiss: miss inside load-use bubble checked");
    endtask

    task automatic test_saturation();
        @(negedge clk); idle(); clr = 1'b1; #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); idle(); dready = 1'b0; #1;
            if (i == 0 || i == 19) chk("sat_freeze_u3", ctl3, FREEZE);
        end
        @(negedge clk); idle(); #1;
        chk_cnt("sat_stall_cnt_u3", {12'd0, sc3}, 16'd15);
        chk_cnt("sat_stall_cnt_u1", sc1, 16'd20);
        @(negedge clk); idle(); dready = 1'b0; clr = 1'b1; #1;
        @(negedge clk); idle(); #1;
        chk_cnt("sat_clear_u3", {12'd0, sc3}, 16'd0);
        chk_cnt("sat_clear_u1", sc1, 16'd0);
        chk_cnt("sat_clear_flush_u1", fc1, 16'd0);
        $display("saturation: 4-bit counter holds at 15 and clears");
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk); idle(); dready = 1'b0; #1;
        chk("rmm_freeze", ctl1, FREEZE);
        @(negedge clk); #1;
        chk("rmm_in_dmiss", ctl1, FREEZE);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rmm_async", ctl1, FLUSH);
        chk_cnt("rmm_cnt_zero", sc1, 16'd0);
        @(negedge clk); rst_n = 1'b1; idle(); #1;
        chk("rmm_first", ctl1, FLUSH);
        chk("rmm_first_u2", ctl2, FLUSH);
        @(negedge clk); #1;
        chk("rmm_second", ctl1, NONE);
        chk_cnt("rmm_stall_cnt", sc1, 16'd0);
        chk_cnt("rmm_flush_cnt", fc1, 16'd0);
        $display("reset_mid_miss: asynchronous reset out of DMISS checked");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_branch_priority();
        test_back_to_back();
        test_imiss();
        test_dmiss_load_use();
        test_saturation();
        test_reset_mid_miss();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
